// File: rtl/vga_rect_plot_arbiter.sv
// Round-robin arbiter that grants one drawing client at a time and streams its filled
// rectangle onto the VGA pixel port. Optional macro VGA_ARB_PRIO0_EN gives client 0 absolute priority.
module vga_rect_plot_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*10-1:0] rect_x,
    input  logic [NUM_REQ*9-1:0]  rect_y,
    input  logic [NUM_REQ*10-1:0] rect_w,
    input  logic [NUM_REQ*9-1:0]  rect_h,
    input  logic [NUM_REQ*24-1:0] rect_color,
    output logic [NUM_REQ-1:0]    ack,
    output logic                  busy,
    output logic [2:0]            grant_id,
    output logic [9:0]            VGA_X,
    output logic [8:0]            VGA_Y,
    output logic [23:0]           VGA_COLOR,
    output logic                  plot
);
    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    localparam logic [10:0] ScreenWL = 11'(SCREEN_W);
    localparam logic [9:0]  ScreenHL = 10'(SCREEN_H);
    localparam logic [2:0]  LastIdx  = 3'(NUM_REQ - 1);
    localparam logic [3:0]  NumReqL  = 4'(NUM_REQ);

    state_t             state_q, state_d;
    logic [2:0]         ptr_q, ptr_d;
    logic [2:0]         grant_q, grant_d;
    logic [9:0]         x0_q, x0_d, w_q, w_d, cx_q, cx_d, vgaX_q, vgaX_d;
    logic [8:0]         y0_q, y0_d, h_q, h_d, cy_q, cy_d, vgaY_q, vgaY_d;
    logic [23:0]        color_q, color_d, vgaColor_q, vgaColor_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               busy_q, busy_d, plot_q, plot_d;

    logic [7:0]         rrReq;
    logic               winFound;
    logic [2:0]         winIdx;
    logic [3:0]         candIdx;
    logic [9:0]         selX, selW;
    logic [8:0]         selY, selH;
    logic [23:0]        selColor;
    logic [10:0]        sumX;
    logic [9:0]         sumY;

    // Winner search starts just past the last granted client and wraps around.
    always_comb begin
        rrReq    = 8'(req);
`ifdef VGA_ARB_PRIO0_EN
        rrReq[0] = 1'b0;
`endif
        winFound = 1'b0;
        winIdx   = '0;
        candIdx  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            candIdx = {1'b0, ptr_q} + 4'(k);
            if (candIdx >= NumReqL) candIdx = candIdx - NumReqL;
            if (!winFound && rrReq[candIdx[2:0]]) begin
                winFound = 1'b1;
                winIdx   = candIdx[2:0];
            end
        end
`ifdef VGA_ARB_PRIO0_EN
        if (req[0]) begin
            winFound = 1'b1;
            winIdx   = '0;
        end
`endif
    end

    always_comb begin
        selX     = '0;
        selY     = '0;
        selW     = '0;
        selH     = '0;
        selColor = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winIdx == 3'(i)) begin
                selX     = rect_x[i*10 +: 10];
                selY     = rect_y[i*9 +: 9];
                selW     = rect_w[i*10 +: 10];
                selH     = rect_h[i*9 +: 9];
                selColor = rect_color[i*24 +: 24];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        x0_d       = x0_q;
        y0_d       = y0_q;
        w_d        = w_q;
        h_d        = h_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        color_d    = color_q;
        vgaX_d     = vgaX_q;
        vgaY_d     = vgaY_q;
        vgaColor_d = vgaColor_q;
        plot_d     = 1'b0;
        ack_d      = '0;
        sumX       = {1'b0, x0_q} + {1'b0, cx_q};
        sumY       = {1'b0, y0_q} + {1'b0, cy_q};
        case (state_q)
            IDLE: begin
                if (winFound) begin
                    grant_d = winIdx;
`ifdef VGA_ARB_PRIO0_EN
                    if (!req[0]) ptr_d = winIdx;
`else
                    ptr_d   = winIdx;
`endif
                    x0_d    = selX;
                    y0_d    = selY;
                    w_d     = selW;
                    h_d     = selH;
                    color_d = selColor;
                    cx_d    = '0;
                    cy_d    = '0;
                    state_d = (selW == 10'd0 || selH == 9'd0) ? DONE : DRAW;
                end
            end
            DRAW: begin
                // Off-screen pixels are suppressed but still take their cycle.
                vgaX_d     = sumX[9:0];
                vgaY_d     = sumY[8:0];
                vgaColor_d = color_q;
                plot_d     = (sumX < ScreenWL) && (sumY < ScreenHL);
                if (cx_q == w_q - 10'd1) begin
                    cx_d = '0;
                    if (cy_q == h_q - 9'd1) state_d = DONE;
                    else                    cy_d    = cy_q + 9'd1;
                end else begin
                    cx_d = cx_q + 10'd1;
                end
            end
            DONE: begin
                for (int i = 0; i < NUM_REQ; i++) ack_d[i] = (grant_q == 3'(i));
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= LastIdx;
            grant_q    <= '0;
            x0_q       <= '0;
            y0_q       <= '0;
            w_q        <= '0;
            h_q        <= '0;
            cx_q       <= '0;
            cy_q       <= '0;
            color_q    <= '0;
            vgaX_q     <= '0;
            vgaY_q     <= '0;
            vgaColor_q <= '0;
            plot_q     <= 1'b0;
            ack_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            x0_q       <= x0_d;
            y0_q       <= y0_d;
            w_q        <= w_d;
            h_q        <= h_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            color_q    <= color_d;
            vgaX_q     <= vgaX_d;
            vgaY_q     <= vgaY_d;
            vgaColor_q <= vgaColor_d;
            plot_q     <= plot_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
        end
    end

    assign ack       = ack_q;
    assign busy      = busy_q;
    assign grant_id  = grant_q;
    assign VGA_X     = vgaX_q;
    assign VGA_Y     = vgaY_q;
    assign VGA_COLOR = vgaColor_q;
    assign plot      = plot_q;

endmodule

// File: tb/tb_vga_rect_plot_arbiter.sv
// Self-checking bench for vga_rect_plot_arbiter: directed and randomized rectangles checked
// against a behavioural model of grant order, clipped pixel stream, ack timing and busy.
module tb_vga_rect_plot_arbiter;
    localparam int NumReq  = 4;
    localparam int ScreenW = 640;
    localparam int ScreenH = 480;

    logic                 CLOCK_50 = 1'b0;
    logic                 reset;
    logic [NumReq-1:0]    req;
    logic [NumReq*10-1:0] rect_x;
    logic [NumReq*9-1:0]  rect_y;
    logic [NumReq*10-1:0] rect_w;
    logic [NumReq*9-1:0]  rect_h;
    logic [NumReq*24-1:0] rect_color;
    logic [NumReq-1:0]    ack;
    logic                 busy;
    logic [2:0]           grant_id;
    logic [9:0]           VGA_X;
    logic [8:0]           VGA_Y;
    logic [23:0]          VGA_COLOR;
    logic                 plot;

    int          testsRun = 0;
    int          testsFailed = 0;
    int          modelPtr;
    int          rx[NumReq], ry[NumReq], rw[NumReq], rh[NumReq];
    logic [23:0] rc[NumReq];
    logic [42:0] expQ[$];
    int          orderQ[$];

    vga_rect_plot_arbiter #(.NUM_REQ(NumReq), .SCREEN_W(ScreenW), .SCREEN_H(ScreenH)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .req(req),
        .rect_x(rect_x), .rect_y(rect_y), .rect_w(rect_w), .rect_h(rect_h),
        .rect_color(rect_color), .ack(ack), .busy(busy), .grant_id(grant_id),
        .VGA_X(VGA_X), .VGA_Y(VGA_Y), .VGA_COLOR(VGA_COLOR), .plot(plot)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic applyStimulus(input int client, input int x, input int y, input int w,
                                 input int h, input logic [23:0] color);
        rx[client] = x;
        ry[client] = y;
        rw[client] = w;
        rh[client] = h;
        rc[client] = color;
        rect_x[client*10 +: 10]     = 10'(x);
        rect_y[client*9 +: 9]       = 9'(y);
        rect_w[client*10 +: 10]     = 10'(w);
        rect_h[client*9 +: 9]       = 9'(h);
        rect_color[client*24 +: 24] = color;
    endtask

    task automatic doReset();
        reset = 1'b1;
        req   = '0;
        tick();
        tick();
        reset    = 1'b0;
        modelPtr = NumReq - 1;
    endtask

    // Raster-order list of on-screen pixels using unwrapped coordinates.
    task automatic buildExpected(input int client);
        expQ.delete();
        for (int r = 0; r < rh[client]; r++)
            for (int c = 0; c < rw[client]; c++)
                if (rx[client] + c < ScreenW && ry[client] + r < ScreenH)
                    expQ.push_back({10'(rx[client] + c), 9'(ry[client] + r), rc[client]});
    endtask

    task automatic buildOrder(input logic [NumReq-1:0] mask);
        logic [NumReq-1:0] pend;
        int                win;
        int                c;
        pend = mask;
        orderQ.delete();
        while (pend != 0) begin
            win = -1;
`ifdef VGA_ARB_PRIO0_EN
            if (pend[0]) win = 0;
`endif
            if (win < 0) begin
                for (int k = 1; k <= NumReq; k++) begin
                    c = (modelPtr + k) % NumReq;
                    if (win < 0 && pend[c]) win = c;
                end
                modelPtr = win;
            end
            orderQ.push_back(win);
            pend[win] = 1'b0;
        end
    endtask

    task automatic serve(input string name, input logic [NumReq-1:0] mask);
        int                t, prevT, expT, busyCnt, idx, win, lim, bad;
        logic [NumReq-1:0] expAck;
        logic [42:0]       obsQ[$];
        buildOrder(mask);
        t = 0; prevT = 0; busyCnt = 0; idx = 0; lim = 10;
        for (int i = 0; i < NumReq; i++)
            if (mask[i]) lim += rw[i] * rh[i] + 2;
        req = mask;
        while (idx < orderQ.size() && t < lim) begin
            tick();
            t++;
            if (busy) busyCnt++;
            if (plot) obsQ.push_back({VGA_X, VGA_Y, VGA_COLOR});
            if (ack != 0) begin
                win = orderQ[idx];
                buildExpected(win);
                expAck = '0;
                expAck[win] = 1'b1;
                expT = prevT + rw[win] * rh[win] + 2;
                testsRun++;
                if (ack !== expAck) begin
                    testsFailed++;
                    $display("[TB] FAIL %s ack: got %b expected %b", name, ack, expAck);
                end
                testsRun++;
                if (t != expT) begin
                    testsFailed++;
                    $display("[TB] FAIL %s ack_cycle client %0d: got %0d expected %0d", name, win, t, expT);
                end
                testsRun++;
                if (grant_id !== 3'(win)) begin
                    testsFailed++;
                    $display("[TB] FAIL %s grant_id: got %0d expected %0d", name, grant_id, win);
                end
                testsRun++;
                if (busyCnt != rw[win] * rh[win] + 1 || busy !== 1'b0) begin
                    testsFailed++;
                    $display("[TB] FAIL %s busy client %0d: got %0d cycles (busy at ack %b) expected %0d cycles (0)",
                             name, win, busyCnt, busy, rw[win] * rh[win] + 1);
                end
                bad = -1;
                if (obsQ.size() != expQ.size()) bad = 0;
                else
                    for (int i = 0; i < expQ.size(); i++)
                        if (bad < 0 && obsQ[i] !== expQ[i]) bad = i;
                testsRun++;
                if (bad >= 0) begin
                    testsFailed++;
                    $display("[TB] FAIL %s pixels client %0d: got %0d pixels (first differs at %0d: %h) expected %0d pixels (%h)",
                             name, win, obsQ.size(), bad, (obsQ.size() > bad) ? obsQ[bad] : 43'h0,
                             expQ.size(), (expQ.size() > bad) ? expQ[bad] : 43'h0);
                end
                req = req & ~ack;
                prevT = t;
                busyCnt = 0;
                obsQ.delete();
                idx++;
            end
        end
        testsRun++;
        if (idx < orderQ.size()) begin
            testsFailed++;
            $display("[TB] FAIL %s timeout: got %0d acks expected %0d", name, idx, orderQ.size());
        end
        req = '0;
        tick();
        testsRun++;
        if (ack !== '0 || plot !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL %s after_ack: got ack=%b plot=%b expected 0 0", name, ack, plot);
        end
    endtask

    task automatic test_reset();
        doReset();
        testsRun++;
        if (ack !== '0 || busy !== 1'b0 || plot !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_ctrl: got ack=%b busy=%b plot=%b expected 0 0 0", ack, busy, plot);
        end
        testsRun++;
        if (grant_id !== 3'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_grant: got %0d expected 0", grant_id);
        end
        testsRun++;
        if (VGA_X !== 10'd0 || VGA_Y !== 9'd0 || VGA_COLOR !== 24'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_pixel: got %0d,%0d,%h expected 0,0,0", VGA_X, VGA_Y, VGA_COLOR);
        end
        tick();
        testsRun++;
        if (busy !== 1'b0 || plot !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL idle_quiet: got busy=%b plot=%b expected 0 0", busy, plot);
        end
    endtask

    task automatic test_single_rect();
        applyStimulus(1, 10, 20, 3, 2, 24'hFF0000);
        serve("single_rect", 4'b0010);
    endtask

    task automatic test_zero_size();
        applyStimulus(2, 100, 100, 0, 5, 24'h00FF00);
        serve("zero_size", 4'b0100);
    endtask

    task automatic test_clipping();
        applyStimulus(3, 638, 479, 4, 2, 24'h0000FF);
        serve("clipping", 4'b1000);
    endtask

    task automatic test_back_to_back();
        doReset();
        for (int i = 0; i < NumReq; i++)
            applyStimulus(i, 40 * i, 30 + i, 1, 1, 24'(32'h101010 * (i + 1)));
        serve("back_to_back", 4'b1111);
    endtask

    task automatic test_reset_mid_draw();
        int   seen, t;
        logic ackSeen;
        doReset();
        applyStimulus(2, 50, 60, 10, 10, 24'hABCDEF);
        req = 4'b0100;
        seen = 0; t = 0;
        while (seen < 3 && t < 10) begin
            tick();
            t++;
            if (plot) seen++;
        end
        testsRun++;
        if (seen != 3) begin
            testsFailed++;
            $display("[TB] FAIL mid_draw_pixels: got %0d expected 3", seen);
        end
        reset = 1'b1;
        req   = '0;
        tick();
        testsRun++;
        if (plot !== 1'b0 || ack !== '0 || busy !== 1'b0 || grant_id !== 3'd0) begin
            testsFailed++;
            $display("[TB] FAIL mid_draw_reset: got plot=%b ack=%b busy=%b grant=%0d expected 0 0 0 0",
                     plot, ack, busy, grant_id);
        end
        reset = 1'b0;
        modelPtr = NumReq - 1;
        ackSeen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (ack != 0) ackSeen = 1'b1;
        end
        testsRun++;
        if (ackSeen !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL mid_draw_noack: got %b expected 0", ackSeen);
        end
        applyStimulus(0, 5, 5, 2, 2, 24'h123456);
        applyStimulus(2, 7, 9, 2, 1, 24'h654321);
        serve("after_reset", 4'b0101);
    endtask

    task automatic test_priority();
        int acks[$];
        int expOrder[3];
        int t;
        doReset();
        applyStimulus(1, 200, 100, 4, 4, 24'h111111);
        applyStimulus(2, 300, 100, 1, 1, 24'h222222);
        applyStimulus(0, 0, 0, 2, 1, 24'h333333);
`ifdef VGA_ARB_PRIO0_EN
        expOrder = '{1, 0, 2};
`else
        expOrder = '{1, 2, 0};
`endif
        req = 4'b0110;
        t = 0;
        while (acks.size() < 3 && t < 60) begin
            tick();
            t++;
            if (t == 3) req[0] = 1'b1;
            for (int i = 0; i < NumReq; i++)
                if (ack[i]) acks.push_back(i);
            req = req & ~ack;
        end
        testsRun++;
        if (acks.size() != 3) begin
            testsFailed++;
            $display("[TB] FAIL priority_count: got %0d acks expected 3", acks.size());
        end
        for (int i = 0; i < 3; i++) begin
            testsRun++;
            if (acks.size() <= i || acks[i] != expOrder[i]) begin
                testsFailed++;
                $display("[TB] FAIL priority_order[%0d]: got %0d expected %0d",
                         i, (acks.size() > i) ? acks[i] : -1, expOrder[i]);
            end
        end
        req = '0;
        tick();
    endtask

    task automatic test_random();
        logic [NumReq-1:0] mask;
        int                x, y;
        doReset();
        for (int iter = 0; iter < 15; iter++) begin
            mask = NumReq'($urandom_range(1, (1 << NumReq) - 1));
            for (int i = 0; i < NumReq; i++) begin
                x = ($urandom_range(0, 3) == 0) ? int'($urandom_range(630, 1023)) : int'($urandom_range(0, 639));
                y = ($urandom_range(0, 3) == 0) ? int'($urandom_range(470, 511)) : int'($urandom_range(0, 479));
                applyStimulus(i, x, y, int'($urandom_range(0, 6)), int'($urandom_range(0, 6)), 24'($urandom));
            end
            serve("random", mask);
        end
    endtask

    initial begin
        reset      = 1'b1;
        req        = '0;
        rect_x     = '0;
        rect_y     = '0;
        rect_w     = '0;
        rect_h     = '0;
        rect_color = '0;
        modelPtr   = NumReq - 1;
        test_reset();
        test_single_rect();
        test_zero_size();
        test_clipping();
        test_back_to_back();
        test_reset_mid_draw();
        test_priority();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
